dm_responder: RTL
=================

Name: dm_responder

Overview:
- Data-memory responder for the pipelined core's DM interface: the target end of the `mem_w`/`wea`/`Addr_out`/`Data_out`/`Data_in` bus driven from the MEM stage.
- Provides a word-addressed RAM with byte-lane writes, a small memory-mapped I/O window (LED register, cycle and store counters) and a post-reset clear sequencer.
- Drives `ready`, which the top level wires to the core's `MIO_ready`.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words; must be a power of two.
- IDX_W, 10, log2(DEPTH); RAM word-index width.
- LED_W, 16, width of the LED output register.
- MMIO_BASE, 30'h3FFF_FF00, word address of the first MMIO register (byte address 0xFFFF_FC00).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_w  in  1  write strobe from the MEM stage.
- wea  in  4  byte-lane enables; bit i covers wdata[8i+7:8i].
- addr  in  32  word address (core byte address >> 2); only addr[29:0] is decoded.
- wdata  in  32  store data.
- rdata  out  32  read data, combinational from addr.
- ready  out  1  high once the clear sequence has finished.
- led  out  LED_W  LED register contents.
- err  out  1  sticky flag: an access hit an unmapped address.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`reset`). All registered state initialises on the rising clk edge while reset=1.
- Reset values: state=CLEAR, clr_idx=0, ready=0, led=0, err=0, cyc_cnt=0, st_cnt=0. RAM contents are undefined until CLEAR completes.
- FSM has two states, CLEAR and RUN.
  - CLEAR: each cycle writes 0 to mem[clr_idx] and increments clr_idx. When clr_idx==DEPTH-1 (that write included), the next state is RUN.
  - CLEAR lasts exactly DEPTH cycles; ready rises in the first RUN cycle.
  - RUN: the terminal state until reset.
- ready is a registered output: 1 iff state==RUN.
- While in CLEAR, all bus writes are ignored, rdata=0 and err is not updated.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR at index 0, and every register returns to its reset value.
- Address decode on addr[29:0]:
  - RAM when addr[29:0] < DEPTH.
  - LED register at MMIO_BASE+0: read/write; reads return zero-extended led.
  - cyc_cnt at MMIO_BASE+1: read-only.
  - st_cnt at MMIO_BASE+2: read-only.
  - Every other address is unmapped.
- Read path: rdata is combinational from the current addr. A write becomes visible on the cycle after its edge; a read in the same cycle as a write to the same word returns the old value.
- RAM write: on an edge with state==RUN and mem_w=1, each lane i with wea[i]=1 gets mem[addr[IDX_W-1:0]][8i+7:8i] <= wdata[8i+7:8i]. Lanes with wea[i]=0 are unchanged.
- mem_w=1 with wea=0 changes no RAM data and does not count.
- LED write: lanes apply byte-wise to led, truncated to LED_W bits.
- Writes to cyc_cnt or st_cnt are ignored and do not set err.
- Unmapped access: mem_w=1 (write) sets err=1. A read (mem_w=0) returns 0 and also sets err=1, but only when addr[31:30]==0, so idle buses with X/high bits don't pollute err. err clears only on reset.
- cyc_cnt: increments by 1 on every RUN cycle; wraps 0xFFFFFFFF→0.
- st_cnt: increments on each accepted RAM write with wea≠0; saturates at 0xFFFFFFFF.
- Simultaneous events: a write and a counter increment in the same edge are independent. The counter read in that cycle returns the pre-edge value.

Decomposition:
- Package dm_pkg holds:
  - the state encoding (ST_CLEAR, ST_RUN);
  - MMIO offsets (MMIO_LED=0, MMIO_CYC=1, MMIO_STC=2);
  - a byte-lane merge function (old word, new word, wea → merged word).
- One natural sub-module, dm_mmio_regs: holds led, cyc_cnt and st_cnt and their write/read mux. The RAM array and clear FSM stay in dm_responder.

Test Plan:
- Assert reset for 1 cycle, then release → ready=0 for 1024 cycles, ready=1 on cycle 1025; reads at addr 0, 5 and 1023 return 0; cyc_cnt reads 0 in the first RUN cycle.
- Write 0x11223344 with wea=4'hF at addr 5, then write 0xAABBCCDD with wea=4'b0010 at addr 5 → addr 5 reads 0x1122CC44; st_cnt=2. A read of addr 5 in the same cycle as the second write returns 0x11223344.
- Write 0xDEADBEEF with wea=4'b0011 to MMIO_BASE+0 → led=16'hBEEF, and a read of MMIO_BASE+0 returns 0x0000BEEF. Writing MMIO_BASE+1 leaves cyc_cnt counting, err=0.
- Write to word addr 0x0000_0400 (just beyond DEPTH) → no RAM change (addr 0 still reads 0), err=1 and stays 1 through later valid accesses.
- Assert reset at clear index 300, release → ready low for another full 1024 cycles. Writes issued during CLEAR are dropped: addr 7 written during CLEAR reads 0 after ready.
- Force cyc_cnt near wrap (run 2^32 cycles or preload via a bench hierarchical deposit to 0xFFFFFFFE) → reads 0xFFFFFFFF, then 0x00000000 on the following cycle.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
// State encoding, MMIO register offsets and the byte-lane merge used by RAM and LED writes.
package dm_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dm_state_t;

  // Word offsets of the MMIO registers relative to MMIO_BASE.
  localparam logic [1:0] MMIO_LED = 2'd0;
  localparam logic [1:0] MMIO_CYC = 2'd1;
  localparam logic [1:0] MMIO_STC = 2'd2;

  // Replace the bytes of old_w selected by wea with the matching bytes of new_w.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  wea);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (wea[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_mmio_regs.sv
// MMIO register bank: LED register, free-running RUN cycle counter, saturating store counter.
// Latency: writes land on the next clk edge; the read mux is combinational from sel_off.
// Backpressure: none, every access completes in the cycle it is presented.
module dm_mmio_regs
  import dm_pkg::*;
#(
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mmio_wr,
  input  logic [1:0]       sel_off,
  input  logic [3:0]       wea,
  input  logic [31:0]      wdata,
  input  logic             ram_store,
  output logic [31:0]      rd_dat,
  output logic [LED_W-1:0] led
);

  logic [31:0] cyc_cnt;
  logic [31:0] st_cnt;
  logic [31:0] led_merged;

  // Only the low LED_W bits of the merged word are kept; the rest is truncated.
  assign led_merged = byte_merge(32'(led), wdata, wea);

  logic unused_led_bits;
  assign unused_led_bits = ^led_merged;

  // LED register: byte-lane writes from the bus while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= '0;
    end else if (run && mmio_wr && sel_off == MMIO_LED) begin
      led <= led_merged[LED_W-1:0];
    end
  end

  // Cycle counter: one tick per RUN cycle, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
    end else if (run) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  // Store counter: counts accepted RAM stores with at least one lane enabled, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_cnt <= '0;
    end else if (ram_store && st_cnt != 32'hFFFF_FFFF) begin
      st_cnt <= st_cnt + 32'd1;
    end
  end

  // Read mux: pre-edge register values, LED zero-extended.
  always_comb begin
    rd_dat = '0;
    case (sel_off)
      MMIO_LED: rd_dat = 32'(led);
      MMIO_CYC: rd_dat = cyc_cnt;
      MMIO_STC: rd_dat = st_cnt;
      default:  rd_dat = '0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: word RAM with byte-lane writes, MMIO window and post-reset clear sequencer.
// Latency: reads combinational from addr; writes visible the cycle after their edge; ready after DEPTH clear cycles.
// Backpressure: none on the bus; accesses while ready=0 are dropped and read as zero.
module dm_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          IDX_W     = 10,
  parameter int          LED_W     = 16,
  parameter logic [29:0] MMIO_BASE = 30'h3FFF_FF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_w,
  input  logic [3:0]       wea,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic [LED_W-1:0] led,
  output logic             err
);

  localparam logic [29:0] LED_ADDR = MMIO_BASE + 30'(MMIO_LED);
  localparam logic [29:0] CYC_ADDR = MMIO_BASE + 30'(MMIO_CYC);
  localparam logic [29:0] STC_ADDR = MMIO_BASE + 30'(MMIO_STC);

  logic [31:0]      mem [DEPTH];
  dm_state_t        state;
  logic [IDX_W-1:0] clr_idx;

  logic [29:0]      a30;
  logic [IDX_W-1:0] ram_idx;
  logic             run;
  logic             ram_hit;
  logic             mmio_hit;
  logic [1:0]       mmio_off;
  logic             ram_we;
  logic             err_set;
  logic [31:0]      mmio_rd;

  assign a30     = addr[29:0];
  assign ram_idx = addr[IDX_W-1:0];
  assign run     = (state == ST_RUN);
  assign ram_hit = (a30 < 30'(DEPTH));

  // Address decode; the top two address bits never take part in selecting a target.
  always_comb begin
    mmio_hit = 1'b1;
    mmio_off = MMIO_LED;
    if (a30 == LED_ADDR)      mmio_off = MMIO_LED;
    else if (a30 == CYC_ADDR) mmio_off = MMIO_CYC;
    else if (a30 == STC_ADDR) mmio_off = MMIO_STC;
    else                      mmio_hit = 1'b0;
  end

  // A store with no lanes enabled is not a store: no data change, no count.
  assign ram_we = run && mem_w && ram_hit && (wea != 4'b0000);

  // Unmapped reads only flag when the high bits are clean, so an idle bus cannot pollute err.
  assign err_set = run && !ram_hit && !mmio_hit && (mem_w || addr[31:30] == 2'b00);

  // Clear sequencer: sweep every RAM word once after reset, then run until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (err_set) err <= 1'b1;
        end
        default: begin
          state <= ST_CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port: clear sweep has priority; bus stores only land once running.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (ram_we) begin
      mem[ram_idx] <= byte_merge(mem[ram_idx], wdata, wea);
    end
  end

  dm_mmio_regs #(
    .LED_W (LED_W)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mmio_wr   (mem_w && mmio_hit),
    .sel_off   (mmio_off),
    .wea       (wea),
    .wdata     (wdata),
    .ram_store (ram_we),
    .rd_dat    (mmio_rd),
    .led       (led)
  );

  // Read path: zero while clearing and for unmapped addresses; pre-edge contents otherwise.
  always_comb begin
    rdata = '0;
    if (run) begin
      if (ram_hit)       rdata = mem[ram_idx];
      else if (mmio_hit) rdata = mmio_rd;
    end
  end

endmodule
